// File: rtl/audio_sd_dac_if.sv
// Sample-vector stream between the audio mixer and the sigma-delta DAC.
// The DAC takes the slave modport. Channel 0 occupies the least significant bits.
interface audio_sd_dac_if #(
    parameter int C_channels = 2,
    parameter int C_in_bits  = 16
) ();
    logic [C_channels*C_in_bits-1:0] s_data;
    logic                            s_valid;
    logic                            s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/audio_sd_dac.sv
// Multichannel noise-shaping sigma-delta DAC for 4-bit resistor audio outputs.
// Each channel has ramped volume, soft mute and a sticky clip flag, and runs a 1st- or 2nd-order modulator.
module audio_sd_dac #(
    parameter int C_channels    = 2,
    parameter int C_in_bits     = 16,
    parameter int C_out_bits    = 4,
    parameter int C_order       = 1,
    parameter int C_ramp_cycles = 256
) (
    input  logic                             i_clk_audio,
    input  logic                             i_rst_n,
    audio_sd_dac_if.slave                    s_if,
    input  logic [C_channels*4-1:0]          i_vol,
    input  logic [C_channels-1:0]            i_mute,
    input  logic                             i_clip_clr,
    output logic [C_channels*C_out_bits-1:0] o_dac,
    output logic [C_channels-1:0]            o_clip
);
    localparam int N  = C_in_bits;
    localparam int M  = C_out_bits;
    localparam int K  = N - M;
    localparam int CW = (C_ramp_cycles > 1) ? $clog2(C_ramp_cycles) : 1;

    if (C_order != 1 && C_order != 2) begin : g_bad_order
        $error("audio_sd_dac: C_order must be 1 or 2");
    end
    if (M >= N || M < 1) begin : g_bad_width
        $error("audio_sd_dac: C_out_bits must be at least 1 and smaller than C_in_bits");
    end
    if (C_ramp_cycles < 1) begin : g_bad_ramp
        $error("audio_sd_dac: C_ramp_cycles must be at least 1");
    end

    logic                    r_ready;
    logic [C_channels*N-1:0] r_sample;
    logic [CW-1:0]           r_ramp_cnt;
    logic                    w_ramp_tick;

    assign s_if.s_ready = r_ready;
    assign w_ramp_tick  = (r_ramp_cnt == CW'(C_ramp_cycles - 1));

    // One-deep input register: always ready once out of reset; a new vector overwrites the held one.
    always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready  <= 1'b0;
            r_sample <= '0;
        end else begin
            r_ready <= 1'b1;
            if (s_if.s_valid && r_ready) begin
                r_sample <= s_if.s_data;
            end
        end
    end

    // Shared ramp timebase; every channel steps its attenuation on the same tick.
    always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ramp_cnt <= '0;
        end else if (w_ramp_tick) begin
            r_ramp_cnt <= '0;
        end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < C_channels; gi++) begin : g_ch
        logic [3:0]          r_att;
        logic [3:0]          w_target;
        logic signed [N-1:0] w_s;
        logic signed [N-1:0] w_x;
        logic [N-1:0]        w_u;
        logic [M-1:0]        w_q;
        logic                w_clip_evt;
        logic [M-1:0]        r_dac;
        logic                r_clip;

        assign w_target = i_mute[gi] ? 4'd15 : i_vol[gi*4 +: 4];
        assign w_s      = r_sample[gi*N +: N];
        // A fully muted channel sits exactly at midscale instead of the residual -1/0 of a 15-step shift.
        assign w_x      = (i_mute[gi] && (r_att == 4'd15)) ? '0 : (w_s >>> r_att);
        assign w_u      = {~w_x[N-1], w_x[N-2:0]};

        always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_att <= 4'd15;
            end else if (w_ramp_tick) begin
                if (r_att < w_target) begin
                    r_att <= r_att + 4'd1;
                end else if (r_att > w_target) begin
                    r_att <= r_att - 4'd1;
                end
            end
        end

        if (C_order == 2) begin : g_o2
            localparam int EW = K + 3;
            localparam int VW = N + 3;
            localparam logic signed [VW-1:0] L_QMAX = VW'((1 << M) - 1);
            localparam logic signed [VW-1:0] L_EMAX = VW'(1 << (K + 1));
            localparam logic signed [VW-1:0] L_EMIN = -L_EMAX;

            logic signed [EW-1:0] r_e1;
            logic signed [EW-1:0] r_e2;
            logic signed [EW-1:0] w_e;
            logic signed [VW-1:0] w_ux;
            logic signed [VW-1:0] w_e1x;
            logic signed [VW-1:0] w_e2x;
            logic signed [VW-1:0] w_v;
            logic signed [VW-1:0] w_qs;
            logic signed [VW-1:0] w_qx;
            logic signed [VW-1:0] w_res;

            assign w_ux  = $signed({3'b000, w_u});
            assign w_e1x = VW'(r_e1);
            assign w_e2x = VW'(r_e2);
            assign w_v   = w_ux + (w_e1x <<< 1) - w_e2x;
            assign w_qs  = w_v >>> K;
            assign w_qx  = $signed({{(VW-M){1'b0}}, w_q});
            // Residual is taken against the clamped code so overload error stays bounded.
            assign w_res = w_v - (w_qx <<< K);

            always_comb begin
                w_q        = '0;
                w_clip_evt = 1'b0;
                if (w_qs[VW-1]) begin
                    w_q        = '0;
                    w_clip_evt = 1'b1;
                end else if (w_qs > L_QMAX) begin
                    w_q        = '1;
                    w_clip_evt = 1'b1;
                end else begin
                    w_q = w_qs[M-1:0];
                end
            end

            always_comb begin
                w_e = w_res[EW-1:0];
                if (w_res > L_EMAX) begin
                    w_e = L_EMAX[EW-1:0];
                end else if (w_res < L_EMIN) begin
                    w_e = L_EMIN[EW-1:0];
                end
            end

            always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_e1 <= '0;
                    r_e2 <= '0;
                end else begin
                    r_e2 <= r_e1;
                    r_e1 <= w_e;
                end
            end
        end else begin : g_o1
            logic [K-1:0] r_err;
            logic [N:0]   w_acc;
            logic [M:0]   w_qraw;

            assign w_acc  = {1'b0, w_u} + {{(M+1){1'b0}}, r_err};
            assign w_qraw = w_acc[N:K];
            // The raw quotient can only overshoot to exactly 2^M, so its top bit is the clip condition.
            assign w_clip_evt = w_qraw[M];
            assign w_q        = w_qraw[M] ? {M{1'b1}} : w_qraw[M-1:0];

            always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_err <= '0;
                end else begin
                    r_err <= w_acc[K-1:0];
                end
            end
        end

        always_ff @(posedge i_clk_audio or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_dac  <= {1'b1, {(M-1){1'b0}}};
                r_clip <= 1'b0;
            end else begin
                r_dac <= w_q;
                if (i_clip_clr) begin
                    r_clip <= 1'b0;
                end else if (w_clip_evt) begin
                    r_clip <= 1'b1;
                end
            end
        end

        assign o_dac[gi*M +: M] = r_dac;
        assign o_clip[gi]       = r_clip;
    end
endmodule
